// File: rtl/vip_maxpool2x2_conv2d_0_if.sv
// FIFO-side bus of the conv2d_0 2x2 max-pool stage: input FIFO read port,
// output FIFO write port and the end-of-frame strobe.
interface vip_maxpool2x2_conv2d_0_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] ff_rdata;
    logic              ff_rdreq;
    logic              ff_empty;
    logic [DWIDTH-1:0] ff_wdata;
    logic              ff_wrreq;
    logic              ff_full;
    logic              frame_done;

    // Pooling stage side
    modport slave (
        input  ff_rdata, ff_empty, ff_full,
        output ff_rdreq, ff_wdata, ff_wrreq, frame_done
    );

    // FIFO / environment side
    modport master (
        output ff_rdata, ff_empty, ff_full,
        input  ff_rdreq, ff_wdata, ff_wrreq, frame_done
    );
endinterface

// File: rtl/vip_maxpool2x2_conv2d_0.sv
// 2x2 stride-2 signed max-pool over a raster feature map (WIDTH x HEIGHT),
// single pass with one row of partial maxima. Optional ReLU on each input
// word is enabled by defining VIP_MAXPOOL_RELU_EN.
module vip_maxpool2x2_conv2d_0 #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned WIDTH  = 112,
    parameter int unsigned HEIGHT = 112
) (
    input  logic                           clock,
    input  logic                           reset,
    vip_maxpool2x2_conv2d_0_if.slave       bus
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned LW   = (HALF   > 1) ? $clog2(HALF)   : 1;

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     rd_vld;
    logic                     hold;
    logic signed [DWIDTH-1:0] hold_reg;
    logic                     hold_last;
    logic signed [DWIDTH-1:0] pair_reg;
    logic signed [DWIDTH-1:0] lbuf [HALF];
    logic [DWIDTH-1:0]        wr_data;
    logic                     wr_req;
    logic                     done_pulse;

    logic signed [DWIDTH-1:0] v;
    logic signed [DWIDTH-1:0] p;
    logic signed [DWIDTH-1:0] r;
    logic signed [DWIDTH-1:0] lb_val;
    logic [LW-1:0]            lb_idx;
    logic                     col_last;
    logic                     row_last;
    logic                     res_vld;
    logic                     res_last;

    // Read request: only when data is available and no result is parked
    assign bus.ff_rdreq   = reset && !bus.ff_empty && !hold;
    assign bus.ff_wdata   = wr_data;
    assign bus.ff_wrreq   = wr_req;
    assign bus.frame_done = done_pulse;

    // Per-word datapath: optional clamp, pair max, row-pair max
    always_comb begin
        v = bus.ff_rdata;
`ifdef VIP_MAXPOOL_RELU_EN
        if (bus.ff_rdata[DWIDTH-1]) begin
            v = '0;
        end
`endif
        lb_idx   = LW'(col >> 1);
        lb_val   = lbuf[lb_idx];
        p        = (pair_reg > v) ? pair_reg : v;
        r        = (lb_val > p) ? lb_val : p;
        col_last = (col == CW'(WIDTH - 1));
        row_last = (row == RW'(HEIGHT - 1));
        res_vld  = rd_vld && col[0] && row[0];
        res_last = col_last && row_last;
    end

    // Column/row position of the word currently being consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= bus.ff_rdreq;
            if (rd_vld) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Pair register and line buffer of even-row partial maxima
    always_ff @(posedge clock) begin
        if (rd_vld && !col[0]) begin
            pair_reg <= v;
        end
        if (rd_vld && col[0] && !row[0]) begin
            lbuf[lb_idx] <= p;
        end
    end

    // Result emission with a single-entry hold under output backpressure
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_data    <= '0;
            wr_req     <= 1'b0;
            done_pulse <= 1'b0;
            hold       <= 1'b0;
            hold_reg   <= '0;
            hold_last  <= 1'b0;
        end else begin
            wr_req     <= 1'b0;
            done_pulse <= 1'b0;
            if (hold) begin
                if (!bus.ff_full) begin
                    wr_data    <= hold_reg;
                    wr_req     <= 1'b1;
                    done_pulse <= hold_last;
                    hold       <= 1'b0;
                end
            end else if (res_vld) begin
                // Present the parked result on wr_data too so it is stable through the stall
                wr_data <= r;
                if (!bus.ff_full) begin
                    wr_req     <= 1'b1;
                    done_pulse <= res_last;
                end else begin
                    hold      <= 1'b1;
                    hold_reg  <= r;
                    hold_last <= res_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_vip_maxpool2x2_conv2d_0.sv
// Scoreboard bench for the 2x2 max-pool stage on a 4x4 frame.
module tb_vip_maxpool2x2_conv2d_0;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    vip_maxpool2x2_conv2d_0_if #(.DWIDTH(DW)) bus_if ();

    vip_maxpool2x2_conv2d_0 #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int   src_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   starve   = 1'b0;
    int   full_mode = 0;   // 0 never full, 1 always full, 2 random
    bit   pend     = 1'b0;
    int   pend_word = 0;

    task automatic check(input string name, input logic signed [DW-1:0] act,
                         input logic signed [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int relu(input int x);
`ifdef VIP_MAXPOOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: each output is the max over its 2x2 block of the frame
    task automatic push_frame(input int f[$]);
        exp_t e;
        int   m;
        for (int br = 0; br < int'(H / 2); br++) begin
            for (int bc = 0; bc < int'(W / 2); bc++) begin
                m = relu(f[(2 * br) * W + 2 * bc]);
                for (int k = 1; k < 4; k++) begin
                    int x;
                    x = relu(f[(2 * br + k / 2) * W + 2 * bc + k % 2]);
                    if (x > m) m = x;
                end
                e.data = DW'(m);
                e.last = (br == int'(H / 2) - 1) && (bc == int'(W / 2) - 1);
                exp_q.push_back(e);
            end
        end
        foreach (f[i]) src_q.push_back(f[i]);
    endtask

    task automatic ramp_frame(input int base, output int f[$]);
        f.delete();
        for (int i = 0; i < int'(W * H); i++) f.push_back(base + i);
    endtask

    task automatic rand_frame(output int f[$]);
        f.delete();
        for (int i = 0; i < int'(W * H); i++) begin
            if ($urandom_range(0, 1) == 0) f.push_back(int'($urandom_range(0, 200)) - 100);
            else f.push_back(int'($urandom));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || pend || exp_q.size() != 0) && n < 2000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        check({name, "_drain_left"}, DW'(exp_q.size()), 0);
    endtask

    // Input FIFO model: ff_empty/ff_full updated just after the edge
    initial begin
        bus_if.ff_empty = 1'b1;
        bus_if.ff_full  = 1'b0;
        bus_if.ff_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            bus_if.ff_empty = (src_q.size() == 0) || (starve && ($urandom_range(0, 1) == 1));
            case (full_mode)
                1:       bus_if.ff_full = 1'b1;
                2:       bus_if.ff_full = ($urandom_range(0, 2) == 0);
                default: bus_if.ff_full = 1'b0;
            endcase
        end
    end

    // Read data returns during the cycle after the request
    initial begin
        forever begin
            @(negedge clock);
            if (pend) begin
                bus_if.ff_rdata = DW'(pend_word);
                pend = 1'b0;
            end
            if (bus_if.ff_rdreq === 1'b1) begin
                check("rdreq_while_empty", DW'(bus_if.ff_empty), 0);
                if (src_q.size() == 0) begin
                    check("rdreq_no_data", 1, 0);
                end else begin
                    pend_word = src_q.pop_front();
                    pend = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every output write against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (bus_if.ff_wrreq === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", bus_if.ff_wdata, e.data);
                        check("frame_done", DW'(bus_if.frame_done), DW'(e.last));
                    end
                end else if (bus_if.frame_done !== 1'b0) begin
                    check("frame_done_no_write", DW'(bus_if.frame_done), 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f[$];
        int g[$];
        exp_t e;

        // Reset state, with data offered so ff_rdreq must still be held low
        repeat (2) @(posedge clock);
        @(negedge clock);
        src_q.push_back(99);
        @(posedge clock);
        @(negedge clock);
        check("rst_rdreq", DW'(bus_if.ff_rdreq), 0);
        check("rst_wrreq", DW'(bus_if.ff_wrreq), 0);
        check("rst_wdata", bus_if.ff_wdata, 0);
        check("rst_frame_done", DW'(bus_if.frame_done), 0);
        src_q.delete();
        @(posedge clock);
        #2 reset = 1'b1;

        // Basic ramp
        ramp_frame(0, f);
        push_frame(f);
        drain("basic");

        // Negative ramp
        ramp_frame(-16, f);
        push_frame(f);
        drain("negative");

        // Backpressure: park the first result and hold it
        full_mode = 1;
        ramp_frame(0, f);
        push_frame(f);
        repeat (12) @(posedge clock);
        e = exp_q[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_wrreq", DW'(bus_if.ff_wrreq), 0);
            check("bp_rdreq", DW'(bus_if.ff_rdreq), 0);
            check("bp_wdata", bus_if.ff_wdata, e.data);
        end
        full_mode = 0;
        drain("backpressure");

        // Input starvation
        starve = 1'b1;
        ramp_frame(0, f);
        push_frame(f);
        drain("starve");
        starve = 1'b0;

        // Reset mid-frame after six words (one result completes first)
        ramp_frame(0, f);
        for (int i = 0; i < 6; i++) src_q.push_back(f[i]);
        e.data = DW'(relu(f[0]));
        foreach (g[i]) g.delete();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (k / 2) * W + k % 2;
            if (relu(f[idx]) > int'(e.data)) e.data = DW'(relu(f[idx]));
        end
        e.last = 1'b0;
        exp_q.push_back(e);
        drain("partial");
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_wdata", bus_if.ff_wdata, 0);
        check("mid_rst_wrreq", DW'(bus_if.ff_wrreq), 0);
        check("mid_rst_rdreq", DW'(bus_if.ff_rdreq), 0);
        src_q.delete();
        pend = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        ramp_frame(0, f);
        push_frame(f);
        drain("post_reset");

        // Back-to-back frames
        ramp_frame(0, f);
        push_frame(f);
        push_frame(f);
        drain("back_to_back");

        // Random frames with random starvation and backpressure
        starve = 1'b1;
        full_mode = 2;
        for (int n = 0; n < 6; n++) begin
            rand_frame(g);
            push_frame(g);
        end
        drain("random");
        starve = 1'b0;
        full_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vip_maxpool2x2_conv2d_0.md
Name: vip_maxpool2x2_conv2d_0

Overview:
- Downstream stage of the conv2d_0 filter1 feature-map core.
- Pops 32-bit signed feature-map words (raster order, WIDTH x HEIGHT per frame) from the filter's output FIFO, applies an optional ReLU and a 2x2 stride-2 max-pool, and pushes (WIDTH/2)x(HEIGHT/2) results into the next stage's input FIFO.
- Holds one row of partial maxima internally, so it runs in a single pass with no frame buffer.

Parameters:
- DWIDTH, 32: feature word width, signed two's complement.
- WIDTH, 112: input columns per row; must be even and >= 2.
- HEIGHT, 112: input rows per frame; must be even and >= 2.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ff_rdata  in  DWIDTH  input FIFO read data; valid the cycle after ff_rdreq.
- ff_rdreq  out  1  input FIFO read request (one word per asserted cycle).
- ff_empty  in  1  input FIFO empty.
- ff_wdata  out  DWIDTH  pooled result to the output FIFO.
- ff_wrreq  out  1  output FIFO write strobe, one cycle per result.
- ff_full  in  1  output FIFO almost_full.
- frame_done  out  1  one-cycle pulse when the last result of a frame is written.

Behaviour:
- Reset (reset=0, async): ff_rdreq=0, ff_wrreq=0, ff_wdata=0, frame_done=0. col=0, row=0, rd_vld=0, hold=0. Line-buffer contents are don't-care. Reset mid-frame discards the partial frame; the next accepted word is treated as row 0, col 0.
- Read side:
  - ff_rdreq = !ff_empty && !hold. It is combinational from registered hold and ff_empty.
  - rd_vld is ff_rdreq delayed by one cycle. A word is consumed only when rd_vld=1.
- Per-word processing:
  - v = RELU(ff_rdata) if RELU_EN is defined, else ff_rdata.
  - Even col: latch v into pair_reg.
  - Odd col: p = smax(pair_reg, v), where smax is a signed compare.
    - Even row: lbuf[col>>1] <= p.
    - Odd row: r = smax(lbuf[col>>1], p) is a result.
- Counters:
  - col increments per consumed word and wraps at WIDTH-1 -> 0, incrementing row.
  - row wraps at HEIGHT-1 -> 0, which starts a new frame. There are no gaps between frames.
- Result emission:
  - If ff_full=0 in the result cycle: ff_wdata<=r and ff_wrreq=1 in the next cycle.
  - If ff_full=1: r is held in hold_reg and hold=1. ff_wdata stays stable and ff_wrreq=0. The first cycle with ff_full=0 writes hold_reg and clears hold.
- Latency: a result is written 1 cycle after the consuming rd_vld cycle when not stalled. Steady-state throughput is 1 word/cycle.
- Hold safety: results occur only at odd columns, so at most one in-flight read can complete after hold rises. That word is always an even column, so it never produces a result. A single hold entry is sufficient and no data is ever dropped or duplicated.
- frame_done pulses in the same cycle as the ff_wrreq for the result at row=HEIGHT-1, col=WIDTH-1.
- Widths: comparisons are DWIDTH signed. Output is DWIDTH with no saturation or rounding.
- Line buffer: WIDTH/2 x DWIDTH registers (or inferred RAM with 1-cycle read, pre-fetched from the col>>1 address on the even column).

Optional Feature:
- Macro: VIP_MAXPOOL_RELU_EN.
- Defined: each input word is clamped to 0 when its MSB is 1, before pooling. All outputs are >= 0.
- Undefined: pure signed max-pool; negative results pass through unchanged.

Test Plan:
- Basic pool. WIDTH=4, HEIGHT=4, inputs 0..15 raster, ff_full=0, ff_empty low while data remains -> writes 5,7,13,15 in order. frame_done pulses with 15 only.
- Negative data. Inputs -16..-1 with WIDTH=HEIGHT=4:
  - Without RELU_EN -> -11,-9,-3,-1.
  - With VIP_MAXPOOL_RELU_EN -> 0,0,0,0.
- Backpressure. ff_full=1 for 20 cycles starting at the first result cycle -> ff_wrreq=0 and ff_wdata=5 stable throughout. ff_rdreq stays 0 after at most one extra read. On release the outputs are 5,7,13,15 with no loss or duplicates.
- Input starvation. ff_empty toggled pseudo-randomly (50%) -> the output sequence is identical to the basic-pool case. ff_rdreq is never asserted while ff_empty=1.
- Reset mid-frame. Assert reset after 6 words consumed, release, then feed a fresh 0..15 frame -> all outputs go 0 during reset. Post-reset output is 5,7,13,15 with one frame_done.
- Back-to-back frames. Feed 32 consecutive words (0..15, 0..15) -> 8 results 5,7,13,15,5,7,13,15 and two frame_done pulses. The counters wrap to row 0, col 0 with no idle cycle.
